// File: rtl/nolinear_pkg.sv
// Shared definitions for the nolinear result path: mode tags, default widths and
// the element slicing helper used by the unpacker.
package nolinear_pkg;

    localparam int NL_FIX_POINT_WIDTH = 16;
    localparam int NL_DATA_NUM        = 32;
    localparam int NL_BF              = 8;

    typedef enum logic [1:0] {
        MODE_SOFTMAX = 2'b00,
        MODE_GELU    = 2'b01,
        MODE_SILU    = 2'b10,
        MODE_ROOT    = 2'b11
    } nl_mode_e;

    // Element 0 lives in the most significant slice of a packed vector.
    function automatic int elem_lsb(input int num, input int width, input int idx);
        return (num - 1 - idx) * width;
    endfunction

endpackage

// File: rtl/nolinear_vec_slot2.sv
// Two-entry vector buffer: A is the head being drained, B holds the next vector.
// A pop with B valid promotes B into A on the same edge, so consecutive vectors have no gap.
module nolinear_vec_slot2 import nolinear_pkg::*; #(
    parameter int VEC_W = NL_FIX_POINT_WIDTH * NL_DATA_NUM
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [VEC_W-1:0] push_data,
    input  nl_mode_e         push_mode,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [VEC_W-1:0] head_data,
    output nl_mode_e         head_mode
);

    logic             a_valid, b_valid;
    logic             a_valid_nxt, b_valid_nxt;
    logic [VEC_W-1:0] a_data, b_data;
    nl_mode_e         a_mode, b_mode;
    logic             do_pop, do_push;
    logic             a_load_push, a_load_b, b_load_push;

    // NOTE: every signal written here gets a default first, otherwise paths that skip an assignment infer latches.
    always_comb begin
        a_valid_nxt = a_valid;
        b_valid_nxt = b_valid;
        a_load_push = 1'b0;
        a_load_b    = 1'b0;
        b_load_push = 1'b0;
        do_pop      = pop & a_valid;
        do_push     = push & ~b_valid;

        if (clear) begin
            a_valid_nxt = 1'b0;
            b_valid_nxt = 1'b0;
        end else begin
            if (do_pop) begin
                if (b_valid) begin
                    a_load_b    = 1'b1;
                    b_valid_nxt = 1'b0;
                end else begin
                    a_valid_nxt = 1'b0;
                end
            end
            // A push lands in A whenever A is (or is about to be) empty, else in B.
            if (do_push) begin
                if (!a_valid_nxt) begin
                    a_load_push = 1'b1;
                    a_valid_nxt = 1'b1;
                end else begin
                    b_load_push = 1'b1;
                    b_valid_nxt = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else begin
            a_valid <= a_valid_nxt;
            b_valid <= b_valid_nxt;
        end
    end

    // NOTE: payload registers are not reset; they are only observed while their valid flag is set.
    always_ff @(posedge clk) begin
        if (a_load_push) begin
            a_data <= push_data;
            a_mode <= push_mode;
        end else if (a_load_b) begin
            a_data <= b_data;
            a_mode <= b_mode;
        end
        if (b_load_push) begin
            b_data <= push_data;
            b_mode <= push_mode;
        end
    end

    assign full      = b_valid;
    assign empty     = ~a_valid;
    assign head_data = a_data;
    assign head_mode = a_mode;

endmodule

// File: rtl/nolinear_out_unpacker.sv
// Replays each captured result vector as a stream of fixed-point elements tagged with
// index, last flag and mode. Outputs depend only on registered state, never on out_ready.
module nolinear_out_unpacker import nolinear_pkg::*; #(
    parameter int FIX_POINT_WIDTH = NL_FIX_POINT_WIDTH,
    parameter int DATA_NUM        = NL_DATA_NUM,
    parameter int Bf              = NL_BF,
    localparam int IDX_W          = $clog2(DATA_NUM)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                vec_valid,
    output logic                                vec_ready,
    input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] vec_data,
    input  logic [1:0]                          vec_mode,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [FIX_POINT_WIDTH-1:0]          out_data,
    output logic [IDX_W-1:0]                    out_idx,
    output logic                                out_last,
    output logic [1:0]                          out_mode
);

    localparam int               VEC_W    = DATA_NUM * FIX_POINT_WIDTH;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_NUM - 1);

    // Bf is carried for the fixed-point format only; it must still describe a legal format.
    if (DATA_NUM < 2 || Bf < 0 || Bf > FIX_POINT_WIDTH) begin : g_param_check
        $error("nolinear_out_unpacker: DATA_NUM must be >= 2 and 0 <= Bf <= FIX_POINT_WIDTH");
    end

    logic             slot_full, slot_empty;
    logic [VEC_W-1:0] head_data;
    nl_mode_e         head_mode;
    logic [IDX_W-1:0] idx;
    logic             a_valid;
    logic             accept, beat, at_last, last_beat;
    int               sel;

    assign a_valid   = ~slot_empty;
    assign vec_ready = ~slot_full;
    assign at_last   = (idx == IDX_LAST);

    // flush discards any accept or beat of its own cycle.
    assign accept    = vec_valid & vec_ready & ~flush;
    assign beat      = a_valid & out_ready & ~flush;
    assign last_beat = beat & at_last;

    nolinear_vec_slot2 #(
        .VEC_W (VEC_W)
    ) u_slots (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (accept),
        .push_data (vec_data),
        .push_mode (nl_mode_e'(vec_mode)),
        .pop       (last_beat),
        .full      (slot_full),
        .empty     (slot_empty),
        .head_data (head_data),
        .head_mode (head_mode)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (flush) begin
            idx <= '0;
        end else if (beat) begin
            idx <= at_last ? '0 : idx + IDX_W'(1);
        end
    end

    // Idle outputs are forced to zero so the un-reset payload never leaks out.
    always_comb begin
        sel       = elem_lsb(DATA_NUM, FIX_POINT_WIDTH, int'(idx));
        out_valid = a_valid;
        out_idx   = idx;
        out_last  = a_valid & at_last;
        out_data  = '0;
        out_mode  = 2'b00;
        if (a_valid) begin
            out_data = head_data[sel +: FIX_POINT_WIDTH];
            out_mode = head_mode;
        end
    end

endmodule

// File: tb/tb_nolinear_out_unpacker.sv
// Scoreboard bench for nolinear_out_unpacker: a DATA_NUM=4 instance for the protocol
// scenarios and a DATA_NUM=32 instance for full-width element ordering.
module tb_nolinear_out_unpacker;
    import nolinear_pkg::*;

    localparam int W   = 16;
    localparam int N4  = 4;
    localparam int N32 = 32;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  idx;
        logic        last;
        logic [1:0]  mode;
    } exp4_t;

    typedef struct packed {
        logic [15:0] data;
        logic [4:0]  idx;
        logic        last;
        logic [1:0]  mode;
    } exp32_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    logic          vec_valid = 1'b0;
    logic          vec_ready;
    logic [63:0]   vec_data = '0;
    logic [1:0]    vec_mode = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   out_data;
    logic [1:0]    out_idx;
    logic          out_last;
    logic [1:0]    out_mode;

    logic          v32_valid = 1'b0;
    logic          v32_ready;
    logic [511:0]  v32_data = '0;
    logic [1:0]    v32_mode = '0;
    logic          o32_valid;
    logic          o32_ready = 1'b0;
    logic [15:0]   o32_data;
    logic [4:0]    o32_idx;
    logic          o32_last;
    logic [1:0]    o32_mode;

    exp4_t  sb4[$];
    exp32_t sb32[$];
    exp4_t  act4, exp4;
    exp32_t act32, exp32;
    int     n_cmp = 0;
    int     n_err = 0;
    int     beats32 = 0;

    always #5 clk = ~clk;

    nolinear_out_unpacker #(.FIX_POINT_WIDTH(W), .DATA_NUM(N4), .Bf(8)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data), .vec_mode(vec_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .out_mode(out_mode)
    );

    nolinear_out_unpacker #(.FIX_POINT_WIDTH(W), .DATA_NUM(N32), .Bf(8)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .vec_valid(v32_valid), .vec_ready(v32_ready), .vec_data(v32_data), .vec_mode(v32_mode),
        .out_valid(o32_valid), .out_ready(o32_ready), .out_data(o32_data),
        .out_idx(o32_idx), .out_last(o32_last), .out_mode(o32_mode)
    );

    // Scoreboard monitors: every beat is compared against the oldest expected element.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            act4 = {out_data, out_idx, out_last, out_mode};
            n_cmp++;
            if (sb4.size() == 0) begin
                n_err++;
                $display("FAIL beat4_unexpected: got data=%h idx=%0d last=%0b mode=%0d, required no beat",
                         out_data, out_idx, out_last, out_mode);
            end else begin
                exp4 = sb4.pop_front();
                if (act4 !== exp4) begin
                    n_err++;
                    $display("FAIL beat4: got data=%h idx=%0d last=%0b mode=%0d, required data=%h idx=%0d last=%0b mode=%0d",
                             act4.data, act4.idx, act4.last, act4.mode,
                             exp4.data, exp4.idx, exp4.last, exp4.mode);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && !flush && o32_valid && o32_ready) begin
            act32 = {o32_data, o32_idx, o32_last, o32_mode};
            beats32++;
            n_cmp++;
            if (sb32.size() == 0) begin
                n_err++;
                $display("FAIL beat32_unexpected: got data=%h idx=%0d, required no beat", o32_data, o32_idx);
            end else begin
                exp32 = sb32.pop_front();
                if (act32 !== exp32) begin
                    n_err++;
                    $display("FAIL beat32: got data=%h idx=%0d last=%0b mode=%0d, required data=%h idx=%0d last=%0b mode=%0d",
                             act32.data, act32.idx, act32.last, act32.mode,
                             exp32.data, exp32.idx, exp32.last, exp32.mode);
                end
            end
        end
    end

    task automatic push_exp4(input logic [63:0] v, input logic [1:0] m);
        exp4_t e;
        for (int i = 0; i < N4; i++) begin
            e.data = v[(N4-1-i)*W +: W];
            e.idx  = 2'(i);
            e.last = (i == N4-1);
            e.mode = m;
            sb4.push_back(e);
        end
    endtask

    // Offer a vector from posedge+1 until accepted; returns at posedge+1 after the accepting edge.
    task automatic send4(input logic [63:0] v, input logic [1:0] m);
        bit acc = 1'b0;
        vec_valid = 1'b1;
        vec_data  = v;
        vec_mode  = m;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (vec_ready && !flush) begin
                push_exp4(v, m);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        vec_valid = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_err++;
            $display("FAIL send4_accept: got no accept in 50 cycles, required accept");
        end
    endtask

    task automatic drain4(input int budget);
        int k = 0;
        while ((sb4.size() != 0 || out_valid) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if (sb4.size() != 0 || out_valid) begin
            n_err++;
            $display("FAIL drain4: got %0d pending, out_valid=%0b, required 0 pending and idle",
                     sb4.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({out_valid, out_data, out_idx, out_last, out_mode, vec_ready} !== {1'b0, 16'h0, 2'd0, 1'b0, 2'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset4: got valid=%0b data=%h idx=%0d last=%0b mode=%0d rdy=%0b, required 0 0000 0 0 0 1",
                     out_valid, out_data, out_idx, out_last, out_mode, vec_ready);
        end
        n_cmp++;
        if ({o32_valid, o32_data, o32_idx, v32_ready} !== {1'b0, 16'h0, 5'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset32: got valid=%0b data=%h idx=%0d rdy=%0b, required 0 0000 0 1",
                     o32_valid, o32_data, o32_idx, v32_ready);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        send4(64'h0100_0200_0300_0400, MODE_SILU);
        n_cmp++;
        if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_data !== 16'h0100) begin
            n_err++;
            $display("FAIL single_latency: got valid=%0b idx=%0d data=%h, required 1 0 0100",
                     out_valid, out_idx, out_data);
        end
        drain4(20);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        send4(64'h0100_0200_0300_0400, MODE_SILU);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, out_data, out_idx, out_last, out_mode} !== {1'b1, 16'h0200, 2'd1, 1'b0, 2'b10}) begin
                n_err++;
                $display("FAIL backpressure_hold[%0d]: got valid=%0b data=%h idx=%0d last=%0b mode=%0d, required 1 0200 1 0 2",
                         i, out_valid, out_data, out_idx, out_last, out_mode);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain4(20);
    endtask

    task automatic test_back_to_back();
        logic exp_rdy;
        out_ready = 1'b1;
        send4(64'h0100_0200_0300_0400, MODE_SILU);
        send4(64'hfd00_fbb0_000d_0008, MODE_GELU);
        for (int i = 0; i < 7; i++) begin
            exp_rdy = (i >= 3);
            n_cmp++;
            if (out_valid !== 1'b1 || vec_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL b2b_cycle[%0d]: got valid=%0b rdy=%0b, required valid=1 rdy=%0b",
                         i, out_valid, vec_ready, exp_rdy);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (out_valid !== 1'b0 || sb4.size() != 0) begin
            n_err++;
            $display("FAIL b2b_end: got valid=%0b pending=%0d, required valid=0 pending=0",
                     out_valid, sb4.size());
        end
        drain4(5);
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b1;
        send4(64'h0100_0200_0300_0400, MODE_SILU);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (out_last !== 1'b1 || out_idx !== 2'd3) begin
            n_err++;
            $display("FAIL simul_at_last: got last=%0b idx=%0d, required last=1 idx=3", out_last, out_idx);
        end
        send4(64'h1111_2222_3333_4444, MODE_ROOT);
        n_cmp++;
        if ({out_valid, out_idx, out_data, out_mode} !== {1'b1, 2'd0, 16'h1111, 2'b11}) begin
            n_err++;
            $display("FAIL simul_next: got valid=%0b idx=%0d data=%h mode=%0d, required 1 0 1111 3",
                     out_valid, out_idx, out_data, out_mode);
        end
        drain4(20);
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        out_ready = 1'b1;
        send4(64'h0100_0200_0300_0400, MODE_SILU);
        send4(64'hfd00_fbb0_000d_0008, MODE_GELU);
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_idx !== 2'd2 || vec_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_pre: got idx=%0d rdy=%0b, required idx=2 rdy=0", out_idx, vec_ready);
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        sb4.delete();
        n_cmp++;
        if (out_valid !== 1'b0 || vec_ready !== 1'b1 || out_idx !== 2'd0) begin
            n_err++;
            $display("FAIL flush_post: got valid=%0b rdy=%0b idx=%0d, required 0 1 0",
                     out_valid, vec_ready, out_idx);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL flush_v2_dropped: got out_valid=1 after flush, required 0");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_rst();
        out_ready = 1'b1;
        send4(64'h0100_0200_0300_0400, MODE_SILU);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_data, out_idx, out_last, out_mode, vec_ready} !== {1'b0, 16'h0, 2'd0, 1'b0, 2'd0, 1'b1}) begin
            n_err++;
            $display("FAIL async_rst: got valid=%0b data=%h idx=%0d last=%0b mode=%0d rdy=%0b, required 0 0000 0 0 0 1",
                     out_valid, out_data, out_idx, out_last, out_mode, vec_ready);
        end
        #2;
        rst = 1'b0;
        sb4.delete();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst_idle: got out_valid=%0b, required 0", out_valid);
        end
    endtask

    task automatic test_data_num32();
        exp32_t e;
        bit     acc = 1'b0;
        int     k = 0;
        for (int i = 0; i < N32; i++) begin
            e.data = {8'(2*i+1), 8'(2*i+2)};
            e.idx  = 5'(i);
            e.last = (i == N32-1);
            e.mode = MODE_SOFTMAX;
            v32_data[(N32-1-i)*W +: W] = e.data;
            sb32.push_back(e);
        end
        beats32   = 0;
        o32_ready = 1'b1;
        v32_mode  = MODE_SOFTMAX;
        v32_valid = 1'b1;
        for (int j = 0; j < 20 && !acc; j++) begin
            @(negedge clk);
            if (v32_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        v32_valid = 1'b0;
        while ((sb32.size() != 0 || o32_valid) && k < 80) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if (!acc || beats32 != N32 || sb32.size() != 0) begin
            n_err++;
            $display("FAIL n32_stream: got accepted=%0b beats=%0d pending=%0d, required 1 32 0",
                     acc, beats32, sb32.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        test_reset();
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_single();
        test_backpressure();
        test_back_to_back();
        test_simultaneous();
        test_flush();
        test_async_rst();
        test_data_num32();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
